// File: rtl/posit_accum_prod_sum.sv
// Sequential accumulator for the ES=2 32-bit posit dot-product datapath.
// Build option: define POSIT_ACCUM_ZERO_SKIP_EN to resolve trivial additions in ALIGN.
module posit_accum_prod_sum #(
  parameter int AMBITS    = 60,
  parameter int SCALE_MAX = 120
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AMBITS+11:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [AMBITS+11:0] out_data,
  output logic              out_truncated,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int MW = AMBITS + 2;  // carry, hidden, fraction
  localparam logic signed [10:0] SMAX = 11'(SCALE_MAX);
  localparam logic signed [10:0] SMIN = -SMAX;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  state_t state, state_n;

  logic              in_sgn, in_inf, in_zero;
  logic [8:0]        in_scale;
  logic [AMBITS-1:0] in_frac;
  assign {in_sgn, in_scale, in_frac, in_inf, in_zero} = in_data;

  logic          acc_sgn, acc_inf, acc_zero, acc_trunc;
  logic [8:0]    acc_scale;
  logic [MW-1:0] acc_mant;

  logic          op_sgn, op_inf, op_zero, op_last;
  logic [8:0]    op_scale;
  logic [MW-1:0] op_mant;
  logic          sub;   // aligned terms have opposite signs
  logic          skip;  // ALIGN resolved the operand; ADD/NORM leave the sum alone

  function automatic logic [6:0] lzc(input logic [AMBITS:0] v);
    logic [6:0] n;
    n = 7'(AMBITS + 1);
    for (int i = 0; i <= AMBITS; i++)
      if (v[i]) n = 7'(AMBITS - i);
    return n;
  endfunction

  // Alignment: order the terms by magnitude and right-shift the smaller one.
  logic          trivial, acc_bigger, lost_bits;
  logic [9:0]    scale_diff;
  logic [5:0]    sh_amt;
  logic [MW-1:0] small_mant, small_shifted;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    trivial    = op_zero | op_inf | acc_zero | acc_inf;
    acc_bigger = ($signed(acc_scale) > $signed(op_scale)) ||
                 ((acc_scale == op_scale) && (acc_mant >= op_mant));
    if (acc_bigger) begin
      scale_diff = {acc_scale[8], acc_scale} - {op_scale[8], op_scale};
      small_mant = op_mant;
    end else begin
      scale_diff = {op_scale[8], op_scale} - {acc_scale[8], acc_scale};
      small_mant = acc_mant;
    end
    sh_amt        = (scale_diff > 10'd63) ? 6'd63 : scale_diff[5:0];
    small_shifted = small_mant >> sh_amt;
    lost_bits     = |(small_mant & ~({MW{1'b1}} << sh_amt));
  end

  logic [MW-1:0] sum_mant;
  assign sum_mant = sub ? (acc_mant - op_mant) : (acc_mant + op_mant);

  // Normalisation back to a hidden bit at position AMBITS, then scale clamp.
  logic [6:0]         lz;
  logic signed [10:0] acc_scale_x, norm_scale;
  logic [MW-1:0]      norm_mant;
  logic               norm_lost, sat_under;
  logic [8:0]         sat_scale;

  assign acc_scale_x = $signed({{2{acc_scale[8]}}, acc_scale});

  always_comb begin
    lz = lzc(acc_mant[AMBITS:0]);
    if (acc_mant[MW-1]) begin
      norm_mant  = acc_mant >> 1;
      norm_scale = acc_scale_x + 11'sd1;
      norm_lost  = acc_mant[0];
    end else begin
      norm_mant  = acc_mant << lz;
      norm_scale = acc_scale_x - $signed({4'b0, lz});
      norm_lost  = 1'b0;
    end
    sat_under = 1'b0;
    if (norm_scale > SMAX) begin
      sat_scale = SMAX[8:0];
    end else if (norm_scale < SMIN) begin
      sat_scale = SMIN[8:0];
      sat_under = 1'b1;
    end else begin
      sat_scale = norm_scale[8:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_first) state_n = in_last ? OUT : IDLE;
          else          state_n = ALIGN;
        end
      end
`ifdef POSIT_ACCUM_ZERO_SKIP_EN
      ALIGN:   state_n = trivial ? (op_last ? OUT : IDLE) : ADD;
`else
      ALIGN:   state_n = ADD;
`endif
      ADD:     state_n = NORM;
      NORM:    state_n = op_last ? OUT : IDLE;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_sgn   <= 1'b0;
      acc_scale <= '0;
      acc_mant  <= '0;
      acc_inf   <= 1'b0;
      acc_zero  <= 1'b1;
      acc_trunc <= 1'b0;
      op_sgn    <= 1'b0;
      op_scale  <= '0;
      op_mant   <= '0;
      op_inf    <= 1'b0;
      op_zero   <= 1'b0;
      op_last   <= 1'b0;
      sub       <= 1'b0;
      skip      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (in_first) begin
            acc_sgn   <= in_sgn;
            acc_scale <= in_scale;
            acc_mant  <= {1'b0, ~in_zero, in_frac};
            acc_inf   <= in_inf;
            acc_zero  <= in_zero;
            acc_trunc <= 1'b0;
          end else begin
            op_sgn    <= in_sgn;
            op_scale  <= in_scale;
            op_mant   <= {1'b0, ~in_zero, in_frac};
            op_inf    <= in_inf;
            op_zero   <= in_zero;
            op_last   <= in_last;
          end
        end
        ALIGN: begin
          skip <= trivial;
          if (!acc_inf) begin
            if (op_inf) begin
              acc_inf <= 1'b1;
            end else if (!op_zero) begin
              if (acc_zero) begin
                acc_sgn   <= op_sgn;
                acc_scale <= op_scale;
                acc_mant  <= op_mant;
                acc_zero  <= 1'b0;
              end else begin
                acc_sgn   <= acc_bigger ? acc_sgn : op_sgn;
                acc_scale <= acc_bigger ? acc_scale : op_scale;
                acc_mant  <= acc_bigger ? acc_mant : op_mant;
                op_mant   <= small_shifted;
                sub       <= acc_sgn ^ op_sgn;
                acc_trunc <= acc_trunc | lost_bits;
              end
            end
          end
        end
        ADD: if (!skip) begin
          if (sum_mant == '0) begin
            acc_zero  <= 1'b1;
            acc_sgn   <= 1'b0;
            acc_scale <= '0;
            acc_mant  <= '0;
          end else begin
            acc_mant  <= sum_mant;
          end
        end
        NORM: if (!skip && !acc_zero) begin
          acc_mant  <= norm_mant;
          acc_scale <= sat_scale;
          acc_trunc <= acc_trunc | norm_lost | sat_under;
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = (state == OUT);
  assign out_data      = out_valid ? {acc_sgn, acc_scale, acc_mant[AMBITS-1:0], acc_inf, acc_zero & ~acc_inf} : '0;
  assign out_truncated = out_valid & acc_trunc;

endmodule

// File: tb/tb_posit_accum_prod_sum.sv
// Scoreboard bench for posit_accum_prod_sum: directed frames plus randomized
// frames checked against an arithmetic reference model of the accumulator.
module tb_posit_accum_prod_sum;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [71:0] in_data = '0;
  logic        in_first = 1'b0, in_last = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] out_data;
  logic        out_truncated, out_valid;
  logic        out_ready;

  posit_accum_prod_sum dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_truncated(out_truncated),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [71:0] data; logic trunc; logic inf; } exp_t;
  typedef struct { bit sgn; int scale; longint unsigned mant; bit inf; bit zero; bit trunc; } acc_t;

  exp_t q[$];
  acc_t m;
  int   n_checks = 0, n_err = 0;
  int   bp_mode = 0;          // 0: ready, 1: random, 2: held low
  bit   hand_pending = 0;
  exp_t hand_exp;
  time  t_first;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m = '{sgn: 0, scale: 0, mant: 0, inf: 0, zero: 1, trunc: 0};
  endfunction

  function automatic exp_t model_word();
    exp_t e;
    logic [8:0] s9;
    logic [63:0] mm;
    s9 = 9'(m.scale);
    mm = m.mant;
    e.data  = {m.sgn, s9, mm[59:0], m.inf, m.zero & ~m.inf};
    e.trunc = m.trunc;
    e.inf   = m.inf;
    return e;
  endfunction

  // Value = mant * 2^(scale-60); hidden bit at 60, carry at 61.
  function automatic void model_apply(input logic [71:0] d, input bit first);
    bit osgn, oinf, ozero, bsgn, ssgn;
    int oscale, bs, ss, sh;
    longint unsigned omant, bm, sm, al, r;
    osgn   = d[71];
    oscale = int'($signed(d[70:62]));
    oinf   = d[1];
    ozero  = d[0];
    omant  = 64'(d[61:2]);
    if (!ozero) omant += 64'd1 << 60;
    if (first) begin
      m = '{sgn: osgn, scale: oscale, mant: omant, inf: oinf, zero: ozero, trunc: 0};
      return;
    end
    if (m.inf) return;
    if (oinf) begin m.inf = 1; return; end
    if (ozero) return;
    if (m.zero) begin
      m.sgn = osgn; m.scale = oscale; m.mant = omant; m.zero = 0;
      return;
    end
    if (m.scale > oscale || (m.scale == oscale && m.mant >= omant)) begin
      bsgn = m.sgn; bs = m.scale; bm = m.mant; ssgn = osgn; ss = oscale; sm = omant;
    end else begin
      bsgn = osgn; bs = oscale; bm = omant; ssgn = m.sgn; ss = m.scale; sm = m.mant;
    end
    sh = (bs - ss > 63) ? 63 : bs - ss;
    al = sm >> sh;
    if ((al << sh) != sm) m.trunc = 1;
    r = (bsgn == ssgn) ? bm + al : bm - al;
    if (r == 0) begin
      m.zero = 1; m.sgn = 0; m.scale = 0; m.mant = 0;
      return;
    end
    m.sgn = bsgn;
    m.scale = bs;
    if (r >= (64'd1 << 61)) begin
      if (r[0]) m.trunc = 1;
      r = r >> 1;
      m.scale++;
    end else begin
      while (r < (64'd1 << 60)) begin r = r << 1; m.scale--; end
    end
    if (m.scale > 120) m.scale = 120;
    if (m.scale < -120) begin m.scale = -120; m.trunc = 1; end
    m.mant = r;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [71:0] d, input bit first, input bit last);
    int waited = 0;
    in_data = d; in_first = first; in_last = last; in_valid = 1'b1;
    while (!in_ready && waited < 300) begin @(negedge clk); waited++; end
    if (!in_ready) begin
      n_checks++; n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
      in_valid = 1'b0;
      return;
    end
    if (first) t_first = $time;
    model_apply(d, first);
    if (last) begin
      if (hand_pending) begin q.push_back(hand_exp); hand_pending = 0; end
      else q.push_back(model_word());
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_hand(input logic [71:0] d, input bit tr, input bit inf);
    hand_exp = '{data: d, trunc: tr, inf: inf};
    hand_pending = 1;
  endtask

  task automatic wait_out(output time t);
    int n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) begin
      n_checks++; n_err++;
      $display("FAIL wait_out: out_valid 0 after %0d cycles, required 1", n);
    end
    t = $time;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL drain: %0d sums outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares the pending sum every cycle it is presented, pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        check("in_ready_during_out", {71'b0, in_ready}, 72'd0);
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_output: actual %h required none", out_data);
        end else begin
          e = q[0];
          if (e.inf) check("out_inf_flags", {70'b0, out_data[1:0]}, 72'd2);
          else       check("out_data", out_data, e.data);
          check("out_truncated", {71'b0, out_truncated}, {71'b0, e.trunc});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [71:0] rand_op(input int base);
    int r, sc;
    logic [8:0] s9;
    logic [63:0] f;
    r = $urandom_range(0, 99);
    if (r < 8)  return 72'h1;
    if (r < 11) return 72'h2;
    r = $urandom_range(0, 9);
    if (r < 5)      sc = base + $urandom_range(0, 8) - 4;
    else if (r < 7) sc = base + $urandom_range(0, 140) - 70;
    else            sc = $urandom_range(0, 240) - 120;
    if (sc > 120)  sc = 120;
    if (sc < -120) sc = -120;
    s9 = 9'(sc);
    f = {$urandom, $urandom};
    return {1'($urandom_range(0, 1)), s9, f[59:0], 2'b00};
  endfunction

  initial begin
    logic [71:0] one, two, p15, n15, three, mthree, tiny, zop, inf_op, big, prev, d;
    logic [8:0]  sneg70;
    time t_o;
    int len, base;
    bit first;

    sneg70 = -9'sd70;
    one    = {1'b0, 9'd0, 60'd0, 2'b00};
    two    = {1'b0, 9'd1, 60'd0, 2'b00};
    p15    = {1'b0, 9'd0, 60'h800000000000000, 2'b00};
    n15    = {1'b1, 9'd0, 60'h800000000000000, 2'b00};
    three  = {1'b0, 9'd1, 60'h800000000000000, 2'b00};
    mthree = {1'b1, 9'd1, 60'h800000000000000, 2'b00};
    tiny   = {1'b0, sneg70, 60'd0, 2'b00};
    zop    = 72'h1;
    inf_op = 72'h2;
    big    = {1'b0, 9'd120, 60'hFFFFFFFFFFFFFFF, 2'b00};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_in_ready", {71'b0, in_ready}, 72'd1);
    check("reset_out_valid", {71'b0, out_valid}, 72'd0);
    check("reset_out_data", out_data, 72'd0);
    check("reset_out_truncated", {71'b0, out_truncated}, 72'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1.0 + 1.0
    send(one, 1, 0);
    expect_hand(two, 0, 0);
    send(one, 0, 1);
    wait_out(t_o);
    check("latency_1p1", 72'((t_o - t_first) / 10), 72'd5);
    drain(50);

    // 1.5 + (-1.5)
    send(p15, 1, 0);
    expect_hand(72'h1, 0, 0);
    send(n15, 0, 1);
    drain(50);

    // alignment loss
    send(one, 1, 0);
    expect_hand(one, 1, 0);
    send(tiny, 0, 1);
    drain(50);

    // inf stickiness, then a fresh frame
    send(three, 1, 0);
    send(inf_op, 0, 0);
    expect_hand(72'h2, 0, 1);
    send(mthree, 0, 1);
    drain(50);
    expect_hand(one, 0, 0);
    send(one, 1, 1);
    drain(50);

    // one-term sum latency
    expect_hand(mthree, 0, 0);
    send(mthree, 1, 1);
    wait_out(t_o);
    check("latency_single", 72'((t_o - t_first) / 10), 72'd1);
    drain(50);

    // backpressure
    bp_mode = 2;
    @(negedge clk);
    expect_hand(three, 0, 0);
    send(three, 1, 1);
    wait_out(t_o);
    repeat (10) @(negedge clk);
    check("bp_still_valid", {71'b0, out_valid}, 72'd1);
    bp_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_released_valid", {71'b0, out_valid}, 72'd0);
    check("bp_released_ready", {71'b0, in_ready}, 72'd1);
    check("bp_queue_empty", 72'(q.size()), 72'd0);

    // reset during ALIGN discards the partial sum
    send(one, 1, 0);
    send(three, 0, 0);
    #1 reset_n = 1'b0;
    model_reset();
    q.delete();
    #1;
    check("midreset_in_ready", {71'b0, in_ready}, 72'd1);
    check("midreset_out_valid", {71'b0, out_valid}, 72'd0);
    check("midreset_out_data", out_data, 72'd0);
    check("midreset_out_truncated", {71'b0, out_truncated}, 72'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_hand(one, 0, 0);
    send(one, 0, 1);
    drain(50);

    // zero operand cycle cost
    send(one, 1, 0);
    expect_hand(one, 0, 0);
    send(zop, 0, 1);
    wait_out(t_o);
`ifdef POSIT_ACCUM_ZERO_SKIP_EN
    check("latency_zero_op", 72'((t_o - t_first) / 10), 72'd3);
`else
    check("latency_zero_op", 72'((t_o - t_first) / 10), 72'd5);
`endif
    drain(50);

    // scale saturation both ways
    send(big, 1, 0);
    send(big, 0, 1);
    drain(50);
    send({1'b0, 9'h188, 60'h800000000000000, 2'b00}, 1, 0);
    send({1'b1, 9'h188, 60'h7FFFFFFFFFFFFFF, 2'b00}, 0, 1);
    drain(50);

    // randomized frames with random backpressure
    bp_mode = 1;
    for (int fr = 0; fr < 400; fr++) begin
      len   = $urandom_range(1, 5);
      base  = $urandom_range(0, 200) - 100;
      first = ($urandom_range(0, 9) != 0);
      prev  = '0;
      for (int i = 0; i < len; i++) begin
        d = rand_op(base);
        if (i == 1 && prev[1:0] == 2'b00 && $urandom_range(0, 9) == 0) d = prev ^ {1'b1, 71'b0};
        send(d, (i == 0) ? first : 1'b0, i == len - 1);
        prev = d;
      end
    end
    drain(5000);
    bp_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
